alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Parameter: OP_W, 4, ALU select width; only 4 is supported.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low; released synchronously to clk by the system.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-008 req0_op  input  4  requester 0 ALU select code.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_op  same as REQ-005..008  requester 1.
REQ-010 alu_a, alu_b  output  32 each  operands to the shared ALU.
REQ-011 alu_s  output  4  select to the shared ALU.
REQ-012 alu_result  input  32  combinational result from the shared ALU.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_data  output  32  registered result.
REQ-016 rsp_id  output  1  requester the response belongs to (0/1).
REQ-017 rsp_err  output  1  op code was illegal (12..15).

Function
REQ-018 FSM states: IDLE, ISSUE, RESP; one-hot or binary, implementer's choice.
REQ-019 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready for that cycle only, latch its a/b/op and id, go to ISSUE; else stay IDLE.
REQ-020 Accept is a valid&&ready handshake; ready is combinational from state, valid inputs and the round-robin pointer; ready is never asserted outside IDLE.
REQ-021 At most one reqN_ready is high in any cycle; ready to a non-valid requester is never asserted.
REQ-022 Arbitration: one valid -> grant it; both valid -> grant the requester not granted last; last_grant register updates on every accept.
REQ-023 ISSUE: alu_a/alu_b/alu_s driven from latched registers; at the clock edge alu_result is captured into rsp_data, rsp_id set, rsp_valid set, state -> RESP.
REQ-024 Illegal op (latched op > 11): alu_s driven 0 during ISSUE, rsp_data captured as 0, rsp_err = 1; legal op -> rsp_err = 0.
REQ-025 alu_a, alu_b, alu_s are 0 in IDLE and RESP.
REQ-026 RESP: rsp_valid, rsp_data, rsp_id, rsp_err held stable until rsp_ready; on rsp_valid&&rsp_ready, rsp_valid clears and state -> IDLE next edge.
REQ-027 Latency: accept edge to rsp_valid high = 1 cycle (rsp_valid visible the cycle after ISSUE); min issue interval 3 cycles with rsp_ready held high.
REQ-028 Requester inputs changing after accept have no effect on the in-flight operation.
REQ-029 rsp_ready while rsp_valid is low is ignored.

Reset
REQ-030 On rst_n low: state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0, latched operands/op = 0, last_grant = 1 (requester 0 wins first tie).
REQ-031 Reset mid-operation (ISSUE or RESP) discards the operation; no response is produced for it.
REQ-032 All outputs are defined (no X) from reset assertion onward.

Verification
REQ-033 Single: req0 a=5, b=3, op=1 (sub) -> req0_ready 1 cycle, alu_s=1 in ISSUE, rsp_data=2, rsp_id=0, rsp_err=0.
REQ-034 Tie after reset: both valid (req0 op=0 a=1 b=2, req1 op=9 a=0xF0 b=0x3C) -> first rsp 3 id 0, then rsp 0x30 id 1; no overlap of readies.
REQ-035 Fairness: both valid continuously, 6 ops -> rsp_id sequence 0,1,0,1,0,1.
REQ-036 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_* stable, req*_ready stays 0, single response delivered on release.
REQ-037 Illegal op: req1 op=13 -> alu_s=0 during ISSUE, rsp_data=0, rsp_err=1, rsp_id=1.
REQ-038 Reset in RESP: rst_n low 1 cycle with rsp_valid=1 -> rsp_valid=0 immediately, state IDLE; next tie grants requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
// Accepts one operation at a time, drives the ALU for one cycle, then holds the registered response.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_s,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rsp_err
);

  localparam logic [OP_W-1:0] LAST_LEGAL_OP = OP_W'(11);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              grant_id;
  logic              accept;
  logic              op_illegal;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;
  logic [OP_W-1:0]   lat_op;
  logic              lat_id;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign op_illegal = (lat_op > LAST_LEGAL_OP);

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_s = '0;
    if (state == ISSUE) begin
      alu_a = lat_a;
      alu_b = lat_b;
      alu_s = op_illegal ? '0 : lat_op;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      lat_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant_id;
            lat_id     <= grant_id;
            lat_a      <= grant_id ? req1_a  : req0_a;
            lat_b      <= grant_id ? req1_b  : req0_b;
            lat_op     <= grant_id ? req1_op : req0_op;
          end
        end
        ISSUE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= op_illegal ? '0 : alu_result;
          rsp_id    <= lat_id;
          rsp_err   <= op_illegal;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
